riscv_alu_seq: RTL and testbench

RISCV_ALU_SEQ -- requirements
Module: riscv_alu_seq

---
 rtl/riscv_alu_seq.sv | 144 ++++++++++++++
 tb/tb_riscv_alu_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/riscv_alu_seq.sv
// Sequential RISC-V ALU with a valid/ready handshake on both sides and a bit-serial shifter.
// Define RISCV_ALU_FAST_SHIFT_EN to replace the serial shifter with a one-cycle barrel shifter.
module riscv_alu_seq #(
  parameter int XLEN = 32
) (
  input  logic            iclk,
  input  logic            irst,
  input  logic            ivalid,
  output logic            oready,
  input  logic [3:0]      ictrl,
  input  logic [XLEN-1:0] ia,
  input  logic [XLEN-1:0] ib,
  output logic            ovalid,
  input  logic            iready,
  output logic [XLEN-1:0] oresult,
  output logic            ozero
);

  localparam logic [3:0] RISCV_ALU_ADD_OP  = 4'd0;
  localparam logic [3:0] RISCV_ALU_SUB_OP  = 4'd1;
  localparam logic [3:0] RISCV_ALU_AND_OP  = 4'd2;
  localparam logic [3:0] RISCV_ALU_OR_OP   = 4'd3;
  localparam logic [3:0] RISCV_ALU_XOR_OP  = 4'd4;
  localparam logic [3:0] RISCV_ALU_SLT_OP  = 4'd5;
  localparam logic [3:0] RISCV_ALU_SLTU_OP = 4'd6;
  localparam logic [3:0] RISCV_ALU_SL_OP   = 4'd7;
  localparam logic [3:0] RISCV_ALU_SR_OP   = 4'd8;
  localparam logic [3:0] RISCV_ALU_SRA_OP  = 4'd9;
  localparam logic [3:0] RISCV_ALU_NOP_OP  = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifndef RISCV_ALU_FAST_SHIFT_EN
    SHIFT = 2'd1,
`endif
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] res_q;
  logic            accept;

  function automatic logic [XLEN-1:0] alu_eval(input logic [3:0] c,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    sa = a;
    sb = b;
    case (c)
      RISCV_ALU_ADD_OP:  alu_eval = a + b;
      RISCV_ALU_SUB_OP:  alu_eval = a - b;
      RISCV_ALU_AND_OP:  alu_eval = a & b;
      RISCV_ALU_OR_OP:   alu_eval = a | b;
      RISCV_ALU_XOR_OP:  alu_eval = a ^ b;
      RISCV_ALU_SLT_OP:  alu_eval = {{(XLEN-1){1'b0}}, (sa < sb)};
      RISCV_ALU_SLTU_OP: alu_eval = {{(XLEN-1){1'b0}}, (a < b)};
`ifdef RISCV_ALU_FAST_SHIFT_EN
      RISCV_ALU_SL_OP:   alu_eval = a << b[4:0];
      RISCV_ALU_SR_OP:   alu_eval = a >> b[4:0];
      RISCV_ALU_SRA_OP:  alu_eval = sa >>> b[4:0];
`endif
      default:           alu_eval = '0;
    endcase
  endfunction

  assign accept  = ivalid && oready;
  assign oready  = (state_q == IDLE) && !irst;
  assign ovalid  = (state_q == DONE);
  assign oresult = res_q;
  assign ozero   = ovalid && (res_q == '0);

`ifdef RISCV_ALU_FAST_SHIFT_EN

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DONE;
      DONE:    if (iready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) res_q <= alu_eval(ictrl, ia, ib);
    end
  end

`else

  logic [3:0] op_q;
  logic [4:0] cnt_q;
  logic       is_shift;

  // One-bit shift step; SRA replicates the sign bit that was loaded from ia.
  function automatic logic [XLEN-1:0] shift_step(input logic [3:0] c,
                                                 input logic [XLEN-1:0] r);
    case (c)
      RISCV_ALU_SL_OP:  shift_step = {r[XLEN-2:0], 1'b0};
      RISCV_ALU_SR_OP:  shift_step = {1'b0, r[XLEN-1:1]};
      RISCV_ALU_SRA_OP: shift_step = {r[XLEN-1], r[XLEN-1:1]};
      default:          shift_step = r;
    endcase
  endfunction

  assign is_shift = (ictrl == RISCV_ALU_SL_OP) || (ictrl == RISCV_ALU_SR_OP) ||
                    (ictrl == RISCV_ALU_SRA_OP);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (is_shift && (ib[4:0] != 5'd0)) ? SHIFT : DONE;
      SHIFT:   if (cnt_q == 5'd1) state_d = DONE;
      DONE:    if (iready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= RISCV_ALU_NOP_OP;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= ictrl;
        cnt_q <= ib[4:0];
        res_q <= is_shift ? ia : alu_eval(ictrl, ia, ib);
      end else if (state_q == SHIFT) begin
        res_q <= shift_step(op_q, res_q);
        cnt_q <= cnt_q - 5'd1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_riscv_alu_seq.sv
// Directed-vector bench for riscv_alu_seq; expected results and latencies are hand-computed.
module tb_riscv_alu_seq;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                         SLT = 4'd5, SLTU = 4'd6, SL = 4'd7, SR = 4'd8, SRA = 4'd9,
                         NOP = 4'd15;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        ivalid = 1'b0;
  logic        oready;
  logic [3:0]  ictrl = 4'd0;
  logic [31:0] ia = '0;
  logic [31:0] ib = '0;
  logic        ovalid;
  logic        iready = 1'b0;
  logic [31:0] oresult;
  logic        ozero;

  int n_vec = 0;
  int n_err = 0;

  riscv_alu_seq #(.XLEN(32)) dut (
    .iclk(iclk), .irst(irst), .ivalid(ivalid), .oready(oready), .ictrl(ictrl),
    .ia(ia), .ib(ib), .ovalid(ovalid), .iready(iready), .oresult(oresult), .ozero(ozero)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int sh_lat(input int n);
`ifdef RISCV_ALU_FAST_SHIFT_EN
    sh_lat = 1;
`else
    sh_lat = 1 + n;
`endif
  endfunction

  // Called #1 after a rising edge; leaves the bench #1 after a rising edge with the block idle.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   lat;
    logic busy_rdy;
    chk({tag, "/rdy"}, 32'(oready), 32'd1);
    ictrl = c; ia = a; ib = b; ivalid = 1'b1;
    @(posedge iclk); #1;
    ivalid = 1'b0; ictrl = ADD; ia = 32'hA5A5_5A5A; ib = 32'h0000_001F;
    lat = 1;
    busy_rdy = 1'b0;
    while (!ovalid && lat < 80) begin
      busy_rdy |= oready;
      @(posedge iclk); #1;
      lat++;
    end
    busy_rdy |= oready;
    chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/res"}, oresult, exp);
    chk({tag, "/zero"}, 32'(ozero), 32'(exp == 32'd0));
    chk({tag, "/busy"}, 32'(busy_rdy), 32'd0);
    iready = 1'b1;
    @(posedge iclk); #1;
    iready = 1'b0;
    chk({tag, "/vld_clr"}, 32'(ovalid), 32'd0);
  endtask

  initial begin
    int   seen_vld;
    #2;
    chk("rst/ovalid", 32'(ovalid), 32'd0);
    chk("rst/oresult", oresult, 32'd0);
    chk("rst/ozero", 32'(ozero), 32'd0);
    chk("rst/oready", 32'(oready), 32'd0);
    @(posedge iclk); #1;
    irst = 1'b0;
    @(posedge iclk); #1;
    chk("rst/rdy_rise", 32'(oready), 32'd1);

    run_op("add_ovf", ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
    run_op("sub_zero", SUB, 32'd5, 32'd5, 32'd0, 1);
    run_op("sub_wrap", SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1);
    run_op("slt_neg", SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("sltu_neg", SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("slt_pos", SLT, 32'd5, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("sltu_pos", SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, 1);
    run_op("and", AND_, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1);
    run_op("or", OR_, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1);
    run_op("xor", XOR_, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1);
    run_op("nop", NOP, 32'd5, 32'd7, 32'd0, 1);
    run_op("unlisted", 4'd12, 32'd5, 32'd7, 32'd0, 1);
    run_op("sra4", SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, sh_lat(4));
    run_op("sr4", SR, 32'h8000_0000, 32'd4, 32'h0800_0000, sh_lat(4));
    run_op("sra_hi_ib", SRA, 32'h7000_0000, 32'h0000_0023, 32'h0E00_0000, sh_lat(3));
    run_op("sl0", SL, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
    run_op("sl31", SL, 32'h1, 32'd31, 32'h8000_0000, sh_lat(31));

    // Backpressure: result held for 3 cycles while a competing request is presented.
    ictrl = ADD; ia = 32'd3; ib = 32'd4; ivalid = 1'b1;
    @(posedge iclk); #1;
    ia = 32'd100; ib = 32'd200;
    chk("bp/vld", 32'(ovalid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge iclk); #1;
      chk("bp/hold", oresult, 32'd7);
      chk("bp/rdy_low", 32'(oready), 32'd0);
    end
    ia = 32'd10; ib = 32'd20;
    iready = 1'b1;
    @(posedge iclk); #1;
    iready = 1'b0;
    chk("bp/idle", 32'(oready), 32'd1);
    chk("bp/no_pend", 32'(ovalid), 32'd0);
    @(posedge iclk); #1;
    ivalid = 1'b0;
    chk("bp/next_vld", 32'(ovalid), 32'd1);
    chk("bp/next_res", oresult, 32'd30);
    iready = 1'b1;
    @(posedge iclk); #1;
    iready = 1'b0;

    // Reset in the middle of a long shift discards it.
    ictrl = SL; ia = 32'h1; ib = 32'd20; ivalid = 1'b1;
    @(posedge iclk); #1;
    ivalid = 1'b0;
    @(posedge iclk); #1;
    irst = 1'b1;
    #1;
    chk("mid_rst/ovalid", 32'(ovalid), 32'd0);
    chk("mid_rst/oresult", oresult, 32'd0);
    chk("mid_rst/oready", 32'(oready), 32'd0);
    @(posedge iclk); #1;
    irst = 1'b0;
    @(posedge iclk); #1;
    chk("mid_rst/rdy", 32'(oready), 32'd1);
    seen_vld = 0;
    for (int i = 0; i < 30; i++) begin
      if (ovalid) seen_vld++;
      @(posedge iclk); #1;
    end
    chk("mid_rst/no_vld", 32'(seen_vld), 32'd0);
    run_op("post_rst", ADD, 32'd1, 32'd2, 32'd3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h, expected 0x%08h", 32'd1, 32'd0);
    $fatal(1, "bench timeout");
  end

endmodule
